uart_rx_oversampler: RTL and testbench
======================================

Name: uart_rx_oversampler

Overview:
Parametrised successor to the UART RX single-mode data sampler. It is the RX oversampling front end:
- Synchronises the raw RX line.
- Runs its own per-bit edge counter.
- Takes a runtime-selectable 1/3/5-sample majority vote centred on the bit middle.
- Emits one voted bit per bit period with a valid strobe and a noise flag.

It sits between the RX pin and the RX FSM / deserializer. The FSM drives SAMP_EN and consumes SAMPLED_BIT on BIT_VLD.

Parameters:
- PRESCALE_W, 6, width of PRESCALE input; max oversampling ratio 2^PRESCALE_W-2 (even).
- SYNC_STAGES, 2, flip-flop stages in the RX_IN synchroniser (legal 2..4).

Ports:
- CLK  input  1  oversampling clock
- RST  input  1  asynchronous, active-high reset
- SAMP_EN  input  1  high while RX FSM is inside a frame; low clears bit timing
- PRESCALE  input  PRESCALE_W  oversampling ratio; even, >=4
- SAMP_MODE  input  2  00=1 sample, 01=3 samples, 10=5 samples, 11=treated as 01
- RX_IN  input  1  asynchronous serial line
- SAMPLED_BIT  output  1  voted bit value
- BIT_VLD  output  1  one-cycle pulse; SAMPLED_BIT/NOISE updated for the completed bit
- NOISE  output  1  samples of the last bit were not unanimous
- EDGE_CNT  output  PRESCALE_W  current edge position within the bit (for FSM/debug)

Behaviour:
- One clock (CLK). RST is asynchronous, active-high.
- Reset values:
  - SAMPLED_BIT=1 (idle mark), BIT_VLD=0, NOISE=0, EDGE_CNT=0.
  - Synchroniser stages=1; vote accumulators=0.
- Synchroniser: RX_IN passes through SYNC_STAGES flops. All sampling uses the synchronised value rx_s. Pin-to-rx_s latency is SYNC_STAGES cycles.
- Shadow config:
  - PRESCALE and SAMP_MODE are captured into p_q/m_q on every cycle where SAMP_EN=1 and EDGE_CNT==0.
  - Changes mid-bit take effect at the next bit.
- Edge counter:
  - SAMP_EN=1: EDGE_CNT increments each cycle and wraps from p_q-1 to 0.
  - SAMP_EN=0: EDGE_CNT forced to 0 on the next edge.
  - On the first enabled cycle EDGE_CNT=0 and config is captured from the live inputs that cycle.
- Sample positions, with c=p_q/2:
  - 1-sample: c.
  - 3-sample: c-1, c, c+1.
  - 5-sample: c-2..c+2.
- Mode degrade: 5-sample mode with p_q<6 is forced to 3-sample. Any p_q<4 is treated as 4.
- Accumulation:
  - At each sample position, ones_cnt (3 bits) increments if rx_s=1; n_cnt (3 bits) increments unconditionally.
  - Both counters clear at the wrap cycle (EDGE_CNT==p_q-1), after use.
- Vote, on the cycle EDGE_CNT==p_q-1 with SAMP_EN=1:
  - Next edge: SAMPLED_BIT <= (2*ones_cnt > n_cnt).
  - NOISE <= (ones_cnt!=0 && ones_cnt!=n_cnt).
  - BIT_VLD <= 1 for exactly one cycle.
  - Strobe latency: p_q cycles after the bit's EDGE_CNT==0 cycle.
- SAMP_EN deasserted mid-bit:
  - Accumulators and EDGE_CNT clear; no BIT_VLD for the partial bit.
  - SAMPLED_BIT and NOISE hold their last values.
- SAMP_EN low on a wrap cycle: no strobe; the enable qualifies the vote.
- BIT_VLD is never high on two consecutive cycles unless p_q==1. p_q==1 cannot occur due to the clamp.
- RST asserted mid-bit: all state returns to reset values immediately. No strobe until a full new bit completes.

Decomposition:
- Shared package uart_rx_pkg holds:
  - SAMP_MODE encodings (MODE_1, MODE_3, MODE_5).
  - MIN_PRESCALE=4 and MIN_PRESCALE_5=6.
  - Function vote_majority(ones, n).
- One sub-module, uart_bit_sync:
  - Parametrised SYNC_STAGES-deep synchroniser with reset value 1.
  - Reused later by the TX-side CTS input.

Test Plan:
- Reset, then SAMP_EN=0 for 20 cycles -> SAMPLED_BIT=1, BIT_VLD=0, NOISE=0, EDGE_CNT=0 throughout.
- PRESCALE=8, MODE_3, RX_IN=0 held for one bit -> BIT_VLD pulses once, 8 cycles after first enabled cycle; SAMPLED_BIT=0, NOISE=0.
- PRESCALE=16, MODE_5, rx_s=1 except a 2-cycle 0-glitch at positions 7..8 -> SAMPLED_BIT=1, NOISE=1. Same glitch at positions 7..9 -> SAMPLED_BIT=0, NOISE=1.
- PRESCALE=4, MODE_5 -> degraded to 3 samples at positions 1,2,3. Pattern 1,0,1 -> SAMPLED_BIT=1, NOISE=1, BIT_VLD every 4 cycles.
- PRESCALE changed 8->16 at EDGE_CNT=3 -> current bit still strobes at count 7. Next bit strobes 16 cycles later.
- SAMP_EN dropped at EDGE_CNT=5 (PRESCALE=8), re-raised 3 cycles later -> no strobe for the aborted bit. Next strobe exactly 8 cycles after re-enable; previous SAMPLED_BIT held meanwhile.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
//   samp_mode_e     : SAMP_MODE encodings (1, 3 or 5 samples per bit)
//   MIN_PRESCALE    : smallest oversampling ratio the sampler will run at
//   MIN_PRESCALE_5  : smallest ratio that leaves room for a 5-sample window
//   vote_majority() : strict majority of 'ones' out of 'n' samples
package uart_rx_pkg;

  typedef enum logic [1:0] {
    MODE_1     = 2'b00,
    MODE_3     = 2'b01,
    MODE_5     = 2'b10,
    MODE_3_ALT = 2'b11
  } samp_mode_e;

  localparam int MIN_PRESCALE   = 4;
  localparam int MIN_PRESCALE_5 = 6;

  // True when more than half of the n samples were ones.
  function automatic logic vote_majority(input logic [2:0] ones, input logic [2:0] n);
    return ({1'b0, ones, 1'b0} > {2'b00, n});
  endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
// Resets to 1 so an idle (mark) serial line reads as idle straight out of reset.
//   clk  : destination clock
//   rst  : asynchronous, active-high reset
//   d    : asynchronous input
//   q    : synchronised output, STAGES cycles behind d
module uart_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stages;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= '1;
    end else begin
      stages <= {stages[STAGES-2:0], d};
    end
  end

  assign q = stages[STAGES-1];

endmodule

// File: rtl/uart_rx_oversampler.sv
// UART RX oversampling front end.
// Synchronises RX_IN, counts oversampling edges within each bit, takes a
// 1/3/5-sample majority vote centred on the bit middle and strobes the result
// once per bit.
//   CLK         : oversampling clock
//   RST         : asynchronous, active-high reset
//   SAMP_EN     : high while the RX FSM is inside a frame; low clears bit timing
//   PRESCALE    : oversampling ratio (even, >= 4; smaller values run as 4)
//   SAMP_MODE   : 00 = 1 sample, 01 = 3 samples, 10 = 5 samples, 11 = 3 samples
//   RX_IN       : asynchronous serial line
//   SAMPLED_BIT : voted value of the last completed bit (1 after reset)
//   BIT_VLD     : one-cycle strobe when SAMPLED_BIT/NOISE are updated
//   NOISE       : samples of the last completed bit disagreed
//   EDGE_CNT    : current edge position inside the bit
module uart_rx_oversampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SAMP_EN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic [1:0]            SAMP_MODE,
  input  logic                  RX_IN,
  output logic                  SAMPLED_BIT,
  output logic                  BIT_VLD,
  output logic                  NOISE,
  output logic [PRESCALE_W-1:0] EDGE_CNT
);

  // One extra bit so that c+2 and p-1 never wrap.
  localparam int CW = PRESCALE_W + 1;

  logic rx_s;

  uart_bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(CLK),
    .rst(RST),
    .d  (RX_IN),
    .q  (rx_s)
  );

  logic [PRESCALE_W-1:0] p_q;
  logic [1:0]            m_q;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [2:0]            ones_cnt;
  logic [2:0]            n_cnt;
  logic                  sampled_bit;
  logic                  bit_vld;
  logic                  noise;

  logic                  capture;
  logic [PRESCALE_W-1:0] p_raw;
  logic [1:0]            m_raw;
  logic [CW-1:0]         p_eff;
  logic [CW-1:0]         c;
  logic [CW-1:0]         pos;
  logic [CW-1:0]         lo;
  logic [CW-1:0]         hi;
  samp_mode_e            mode;
  logic                  hit;
  logic                  wrap;
  logic [2:0]            ones_now;
  logic [2:0]            n_now;

  // At the start of each bit the live inputs are used directly, so the first
  // enabled cycle already runs with the configuration being captured.
  assign capture = SAMP_EN && (edge_cnt == '0);
  assign p_raw   = capture ? PRESCALE  : p_q;
  assign m_raw   = capture ? SAMP_MODE : m_q;

  always_comb begin
    p_eff = {1'b0, p_raw};
    mode  = MODE_3;
    lo    = '0;
    hi    = '0;

    if (p_eff < CW'(MIN_PRESCALE)) begin
      p_eff = CW'(MIN_PRESCALE);
    end

    case (m_raw)
      2'b00:   mode = MODE_1;
      // A 5-wide window does not fit inside a bit shorter than 6 edges.
      2'b10:   mode = (p_eff < CW'(MIN_PRESCALE_5)) ? MODE_3 : MODE_5;
      default: mode = MODE_3;
    endcase

    c   = p_eff >> 1;
    pos = {1'b0, edge_cnt};

    case (mode)
      MODE_1: begin
        lo = c;
        hi = c;
      end
      MODE_5: begin
        lo = c - CW'(2);
        hi = c + CW'(2);
      end
      default: begin
        lo = c - CW'(1);
        hi = c + CW'(1);
      end
    endcase
  end

  assign hit  = (pos >= lo) && (pos <= hi);
  assign wrap = (pos == p_eff - CW'(1));

  // With small ratios the last sample lands on the wrap cycle itself, so the
  // vote uses the counts including the current cycle's sample.
  assign ones_now = ones_cnt + {2'b00, hit & rx_s};
  assign n_now    = n_cnt + {2'b00, hit};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p_q         <= PRESCALE_W'(MIN_PRESCALE);
      m_q         <= MODE_1;
      edge_cnt    <= '0;
      ones_cnt    <= '0;
      n_cnt       <= '0;
      sampled_bit <= 1'b1;
      bit_vld     <= 1'b0;
      noise       <= 1'b0;
    end else begin
      bit_vld <= 1'b0;

      if (capture) begin
        p_q <= PRESCALE;
        m_q <= SAMP_MODE;
      end

      if (!SAMP_EN) begin
        edge_cnt <= '0;
        ones_cnt <= '0;
        n_cnt    <= '0;
      end else if (wrap) begin
        edge_cnt    <= '0;
        ones_cnt    <= '0;
        n_cnt       <= '0;
        sampled_bit <= vote_majority(ones_now, n_now);
        noise       <= (ones_now != 3'd0) && (ones_now != n_now);
        bit_vld     <= 1'b1;
      end else begin
        edge_cnt <= edge_cnt + PRESCALE_W'(1);
        ones_cnt <= ones_now;
        n_cnt    <= n_now;
      end
    end
  end

  assign SAMPLED_BIT = sampled_bit;
  assign BIT_VLD     = bit_vld;
  assign NOISE       = noise;
  assign EDGE_CNT    = edge_cnt;

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Self-checking bench for uart_rx_oversampler.
module tb_uart_rx_oversampler;

  logic       clk;
  logic       rst;
  logic       samp_en;
  logic [5:0] prescale;
  logic [1:0] samp_mode;
  logic       rx_in;
  logic       sampled_bit;
  logic       bit_vld;
  logic       noise;
  logic [5:0] edge_cnt;

  int total = 0;
  int bad   = 0;

  uart_rx_oversampler #(
    .PRESCALE_W (6),
    .SYNC_STAGES(2)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .SAMP_EN    (samp_en),
    .PRESCALE   (prescale),
    .SAMP_MODE  (samp_mode),
    .RX_IN      (rx_in),
    .SAMPLED_BIT(sampled_bit),
    .BIT_VLD    (bit_vld),
    .NOISE      (noise),
    .EDGE_CNT   (edge_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pat bit j = value rx_s must have at edge position j of the bit.
  typedef struct {
    logic [5:0]  prescale;
    logic [1:0]  mode;
    int          p_eff;
    logic [31:0] pat;
    logic        exp_bit;
    logic        exp_noise;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One isolated bit: idle preroll, p_eff enabled cycles, strobe check.
  // RX_IN is driven two cycles ahead because of the synchroniser latency.
  task automatic run_vec(input vec_t v, input int idx);
    samp_en   = 1'b0;
    prescale  = v.prescale;
    samp_mode = v.mode;
    for (int k = 0; k < 5; k++) begin
      rx_in = (k == 4) ? v.pat[1] : v.pat[0];
      tick();
      chk($sformatf("v%0d idle vld", idx), int'(bit_vld), 0);
    end
    for (int j = 0; j < v.p_eff; j++) begin
      chk($sformatf("v%0d cnt@%0d", idx, j), int'(edge_cnt), j);
      chk($sformatf("v%0d vld@%0d", idx, j), int'(bit_vld), 0);
      samp_en = 1'b1;
      rx_in   = v.pat[j+2];
      tick();
    end
    chk($sformatf("v%0d strobe", idx), int'(bit_vld), 1);
    chk($sformatf("v%0d bit", idx), int'(sampled_bit), int'(v.exp_bit));
    chk($sformatf("v%0d noise", idx), int'(noise), int'(v.exp_noise));
    chk($sformatf("v%0d cnt wrap", idx), int'(edge_cnt), 0);
    $display("vec %0d: prescale=%0d mode=%0d bit=%0d noise=%0d", idx, v.prescale, v.mode,
             sampled_bit, noise);
    samp_en = 1'b0;
    tick();
    chk($sformatf("v%0d vld after", idx), int'(bit_vld), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat4;
    int         exp_cnt;
    logic       exp_bit;

    //           prescale mode   p_eff pattern         bit   noise
    vecs[0]  = '{6'd8,  2'b01, 8,  32'hFFFF_0000, 1'b0, 1'b0};
    vecs[1]  = '{6'd16, 2'b10, 16, 32'hFFFF_FE7F, 1'b1, 1'b1};
    vecs[2]  = '{6'd16, 2'b10, 16, 32'hFFFF_FC7F, 1'b0, 1'b1};
    vecs[3]  = '{6'd4,  2'b10, 4,  32'hFFFF_FFFB, 1'b1, 1'b1};
    vecs[4]  = '{6'd8,  2'b00, 8,  32'hFFFF_FFEF, 1'b0, 1'b0};
    vecs[5]  = '{6'd8,  2'b00, 8,  32'hFFFF_0010, 1'b1, 1'b0};
    vecs[6]  = '{6'd8,  2'b11, 8,  32'hFFFF_FFF7, 1'b1, 1'b1};
    vecs[7]  = '{6'd2,  2'b00, 4,  32'hFFFF_FFFB, 1'b0, 1'b0};
    vecs[8]  = '{6'd6,  2'b10, 6,  32'hFFFF_FFF9, 1'b1, 1'b1};
    vecs[9]  = '{6'd6,  2'b10, 6,  32'hFFFF_FFCD, 1'b0, 1'b1};
    vecs[10] = '{6'd16, 2'b10, 16, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[11] = '{6'd8,  2'b01, 8,  32'hFFFF_0018, 1'b1, 1'b1};

    // Reset and idle.
    rst       = 1'b1;
    samp_en   = 1'b0;
    prescale  = 6'd8;
    samp_mode = 2'b00;
    rx_in     = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle bit", int'(sampled_bit), 1);
      chk("idle vld", int'(bit_vld), 0);
      chk("idle noise", int'(noise), 0);
      chk("idle cnt", int'(edge_cnt), 0);
    end
    $display("reset/idle: 20 cycles observed");

    // Table-driven single bits.
    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], i);
    end

    // Back-to-back bits at ratio 4 with mode 5 degraded to 3 samples.
    prescale  = 6'd4;
    samp_mode = 2'b10;
    pat4      = 4'b1011;
    for (int t = -4; t <= 12; t++) begin
      if (t >= 0) begin
        chk($sformatf("b2b cnt@%0d", t), int'(edge_cnt), t % 4);
        chk($sformatf("b2b vld@%0d", t), int'(bit_vld), (t > 0 && t % 4 == 0) ? 1 : 0);
        if (t > 0 && t % 4 == 0) begin
          chk($sformatf("b2b bit@%0d", t), int'(sampled_bit), 1);
          chk($sformatf("b2b noise@%0d", t), int'(noise), 1);
          $display("b2b strobe at %0d: bit=%0d noise=%0d", t, sampled_bit, noise);
        end
      end
      samp_en = (t >= 0 && t < 12);
      rx_in   = pat4[(t + 6) % 4];
      tick();
    end
    chk("b2b vld end", int'(bit_vld), 0);

    // Prescale change mid-bit takes effect at the next bit.
    samp_en   = 1'b0;
    prescale  = 6'd8;
    samp_mode = 2'b01;
    rx_in     = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    for (int t = 0; t <= 25; t++) begin
      exp_cnt = (t < 8) ? t : (t < 24) ? t - 8 : 0;
      chk($sformatf("pchg cnt@%0d", t), int'(edge_cnt), exp_cnt);
      chk($sformatf("pchg vld@%0d", t), int'(bit_vld), (t == 8 || t == 24) ? 1 : 0);
      if (t == 8 || t == 24) begin
        chk($sformatf("pchg bit@%0d", t), int'(sampled_bit), 0);
        $display("pchg strobe at %0d: bit=%0d", t, sampled_bit);
      end
      samp_en = (t < 24);
      if (t == 3) prescale = 6'd16;
      tick();
    end

    // SAMP_EN dropped mid-bit: aborted bit never strobes, output held.
    prescale  = 6'd8;
    samp_mode = 2'b01;
    for (int t = 0; t <= 17; t++) begin
      exp_cnt = (t <= 5) ? t : (t <= 8) ? 0 : (t < 16) ? t - 8 : 0;
      exp_bit = (t < 16) ? 1'b0 : 1'b1;
      chk($sformatf("abort cnt@%0d", t), int'(edge_cnt), exp_cnt);
      chk($sformatf("abort vld@%0d", t), int'(bit_vld), (t == 16) ? 1 : 0);
      chk($sformatf("abort bit@%0d", t), int'(sampled_bit), int'(exp_bit));
      if (t == 16) begin
        chk("abort noise", int'(noise), 0);
        $display("abort strobe at %0d: bit=%0d noise=%0d", t, sampled_bit, noise);
      end
      samp_en = !(t >= 5 && t <= 7) && (t < 16);
      rx_in   = (t >= 6);
      tick();
    end

    // Reset asserted mid-bit.
    run_vec(vecs[0], 0);
    prescale  = 6'd8;
    samp_mode = 2'b01;
    rx_in     = 1'b0;
    for (int t = 0; t <= 15; t++) begin
      exp_cnt = (t <= 4) ? t : (t <= 6) ? 0 : (t < 14) ? t - 6 : 0;
      exp_bit = (t <= 4 || t >= 14) ? 1'b0 : 1'b1;
      chk($sformatf("rst cnt@%0d", t), int'(edge_cnt), exp_cnt);
      chk($sformatf("rst vld@%0d", t), int'(bit_vld), (t == 14) ? 1 : 0);
      chk($sformatf("rst bit@%0d", t), int'(sampled_bit), int'(exp_bit));
      samp_en = (t < 14);
      if (t == 6) rst = 1'b0;
      if (t == 4) begin
        rst = 1'b1;
        #1;
        chk("rst async cnt", int'(edge_cnt), 0);
        chk("rst async bit", int'(sampled_bit), 1);
        chk("rst async vld", int'(bit_vld), 0);
        chk("rst async noise", int'(noise), 0);
        $display("reset mid-bit: cnt=%0d bit=%0d", edge_cnt, sampled_bit);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
